dual_port_ram_be: RTL and testbench

Parametrised true dual-port RAM with per-byte write enables and a configurable read pipeline depth (1 or 2 cycles). It adds a selectable read-during-write policy, deterministic write-write collision resolution with a flag, and an optional post-reset memory-clear sequencer. It is the general-purpose storage primitive under the team's FIFOs, queues and register-file style buffers.

---
 rtl/dual_port_ram_be_if.sv | 35 +++
 rtl/dual_port_ram_be.sv | 171 +++++++++++++++++
 tb/tb_dual_port_ram_be.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_be_if.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_ram_be_if
// Purpose  : Two-port request/response bundle for dual_port_ram_be.
// Revision : 1.0 - initial release
// ============================================================================
interface dual_port_ram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int RAM_DEPTH  = 256
);
  localparam int LB_RAM_DEPTH = $clog2(RAM_DEPTH);
  localparam int NB           = DATA_WIDTH / BYTE_WIDTH;

  logic                    en0,    en1;
  logic                    wr_en0, wr_en1;
  logic [NB-1:0]           be0,    be1;
  logic [LB_RAM_DEPTH-1:0] addr0,  addr1;
  logic [DATA_WIDTH-1:0]   din0,   din1;
  logic [DATA_WIDTH-1:0]   dout0,  dout1;
  logic                    dout_valid0, dout_valid1;
  logic                    collision;
  logic                    init_busy;

  modport master (
    output en0, en1, wr_en0, wr_en1, be0, be1, addr0, addr1, din0, din1,
    input  dout0, dout1, dout_valid0, dout_valid1, collision, init_busy
  );

  modport slave (
    input  en0, en1, wr_en0, wr_en1, be0, be1, addr0, addr1, din0, din1,
    output dout0, dout1, dout_valid0, dout_valid1, collision, init_busy
  );
endinterface
`default_nettype wire

// File: rtl/dual_port_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_ram_be
// Purpose  : True dual-port byte-enable RAM, 1/2-cycle read pipeline,
//            RDW policy, port-0-wins collision merge. Optional post-reset
//            clear sequencer built when DPRAM_INIT_CLEAR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dual_port_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int RAM_DEPTH  = 256,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic               clk,
  input  logic               rst,
  dual_port_ram_be_if.slave  bus
);
  localparam int LB_RAM_DEPTH = $clog2(RAM_DEPTH);
  localparam int NB           = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0]   r_mem [RAM_DEPTH];

  logic                    w_busy;
  logic                    w_clr_we;
  logic [LB_RAM_DEPTH-1:0] w_clr_addr;
  logic                    w_acc0, w_acc1;
  logic                    w_same;
  logic [NB-1:0]           w_be0, w_be1, w_both;
  logic [DATA_WIDTH-1:0]   w_old0, w_old1, w_new0, w_new1;
  logic [DATA_WIDTH-1:0]   w_rdat0, w_rdat1;
  logic                    r_coll;
  logic                    r_v0, r_v1;
  logic [DATA_WIDTH-1:0]   r_d0, r_d1;

  assign w_acc0 = bus.en0 & ~w_busy;
  assign w_acc1 = bus.en1 & ~w_busy;
  assign w_same = (bus.addr0 == bus.addr1);
  assign w_be0  = (w_acc0 & bus.wr_en0) ? bus.be0 : '0;
  assign w_be1  = (w_acc1 & bus.wr_en1) ? bus.be1 : '0;
  assign w_both = w_same ? (w_be0 & w_be1) : '0;
  assign w_old0 = r_mem[bus.addr0];
  assign w_old1 = r_mem[bus.addr1];

  // Post-write word as seen from each port; on a shared address both
  // resolve to the same merged word with port 0 owning contested bytes.
  always_comb begin
    w_new0 = w_old0;
    w_new1 = w_old1;
    for (int b = 0; b < NB; b++) begin
      if (w_same && w_be1[b]) w_new0[b*BYTE_WIDTH +: BYTE_WIDTH] = bus.din1[b*BYTE_WIDTH +: BYTE_WIDTH];
      if (w_be0[b])           w_new0[b*BYTE_WIDTH +: BYTE_WIDTH] = bus.din0[b*BYTE_WIDTH +: BYTE_WIDTH];
      if (w_be1[b])           w_new1[b*BYTE_WIDTH +: BYTE_WIDTH] = bus.din1[b*BYTE_WIDTH +: BYTE_WIDTH];
      if (w_same && w_be0[b]) w_new1[b*BYTE_WIDTH +: BYTE_WIDTH] = bus.din0[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign w_rdat0 = ((RDW_MODE == 1) && w_acc0 && bus.wr_en0) ? w_new0 : w_old0;
  assign w_rdat1 = ((RDW_MODE == 1) && w_acc1 && bus.wr_en1) ? w_new1 : w_old1;

  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[w_clr_addr] <= '0;
    for (int b = 0; b < NB; b++) begin
      if (w_be0[b])
        r_mem[bus.addr0][b*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din0[b*BYTE_WIDTH +: BYTE_WIDTH];
      if (w_be1[b] && !w_both[b])
        r_mem[bus.addr1][b*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din1[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_coll <= 1'b0;
    else     r_coll <= |w_both;
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  r_p_v0, r_p_v1;
      logic [DATA_WIDTH-1:0] r_p_d0, r_p_d1;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_p_v0 <= 1'b0;
          r_p_v1 <= 1'b0;
          r_p_d0 <= '0;
          r_p_d1 <= '0;
          r_v0   <= 1'b0;
          r_v1   <= 1'b0;
          r_d0   <= '0;
          r_d1   <= '0;
        end else begin
          r_p_v0 <= w_acc0;
          r_p_v1 <= w_acc1;
          if (w_acc0) r_p_d0 <= w_rdat0;
          if (w_acc1) r_p_d1 <= w_rdat1;
          r_v0 <= r_p_v0;
          r_v1 <= r_p_v1;
          if (r_p_v0) r_d0 <= r_p_d0;
          if (r_p_v1) r_d1 <= r_p_d1;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v0 <= 1'b0;
          r_v1 <= 1'b0;
          r_d0 <= '0;
          r_d1 <= '0;
        end else begin
          r_v0 <= w_acc0;
          r_v1 <= w_acc1;
          if (w_acc0) r_d0 <= w_rdat0;
          if (w_acc1) r_d1 <= w_rdat1;
        end
      end
    end
  endgenerate

`ifdef DPRAM_INIT_CLEAR_EN
  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [LB_RAM_DEPTH-1:0] c_last = LB_RAM_DEPTH'(RAM_DEPTH - 1);
  localparam logic [LB_RAM_DEPTH-1:0] c_one  = LB_RAM_DEPTH'(1);

  state_t                  r_state, w_state_nxt;
  logic [LB_RAM_DEPTH-1:0] r_clr_cnt, w_clr_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_busy        = 1'b0;
    w_clr_we      = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_busy        = 1'b1;
        w_clr_we      = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + c_one;
        if (r_clr_cnt == c_last) w_state_nxt = S_RUN;
      end
      default: ;
    endcase
  end

  assign w_clr_addr = r_clr_cnt;
`else
  assign w_busy     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign bus.dout0       = r_d0;
  assign bus.dout1       = r_d1;
  assign bus.dout_valid0 = r_v0;
  assign bus.dout_valid1 = r_v1;
  assign bus.collision   = r_coll;
  assign bus.init_busy   = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_ram_be
// Purpose  : Drives two DUT builds (lat1/old-data and lat2/new-data) with the
//            same stimulus and compares both against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram_be;
  localparam int DW = 32, BW = 8, DEPTH = 16, LB = 4, NB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          en0, en1, wr0, wr1;
  logic [NB-1:0] be0, be1;
  logic [LB-1:0] a0, a1;
  logic [DW-1:0] d0, d1;

  dual_port_ram_be_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .RAM_DEPTH(DEPTH)) bus_a ();
  dual_port_ram_be_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .RAM_DEPTH(DEPTH)) bus_b ();

  assign bus_a.en0 = en0;   assign bus_a.en1 = en1;   assign bus_a.wr_en0 = wr0; assign bus_a.wr_en1 = wr1;
  assign bus_a.be0 = be0;   assign bus_a.be1 = be1;   assign bus_a.addr0  = a0;  assign bus_a.addr1  = a1;
  assign bus_a.din0 = d0;   assign bus_a.din1 = d1;
  assign bus_b.en0 = en0;   assign bus_b.en1 = en1;   assign bus_b.wr_en0 = wr0; assign bus_b.wr_en1 = wr1;
  assign bus_b.be0 = be0;   assign bus_b.be1 = be1;   assign bus_b.addr0  = a0;  assign bus_b.addr1  = a1;
  assign bus_b.din0 = d0;   assign bus_b.din1 = d1;

  dual_port_ram_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .RAM_DEPTH(DEPTH),
                     .RD_LATENCY(1), .RDW_MODE(0)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  dual_port_ram_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .RAM_DEPTH(DEPTH),
                     .RD_LATENCY(2), .RDW_MODE(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  // Reference model: a plain word array plus a schedule of expected
  // responses indexed by the cycle in which they must appear.
  logic [DW-1:0] mem_m [DEPTH];
  int            busy_left;
  logic          coll_m;
  logic          exp_v [2][2][8];
  logic [DW-1:0] exp_d [2][2][8];
  logic [DW-1:0] last_d [2][2];
  int            checks = 0, errors = 0, cyc = 0;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic bit rdw_new(int d);
    return d != 0;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] after [DEPTH];
    logic busy, acc0, acc1, w0, w1;
    int slot;
    if (rst) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          last_d[d][p] = '0;
          for (int k = 0; k < 8; k++) exp_v[d][p][k] = 1'b0;
        end
      coll_m = 1'b0;
`ifdef DPRAM_INIT_CLEAR_EN
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
`else
      busy_left = 0;
`endif
      return;
    end
    busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    acc0 = en0 && !busy;
    acc1 = en1 && !busy;
    w0   = acc0 && wr0;
    w1   = acc1 && wr1;
    after = mem_m;
    for (int b = 0; b < NB; b++)
      if (w1 && be1[b]) after[a1][b*BW +: BW] = d1[b*BW +: BW];
    for (int b = 0; b < NB; b++)
      if (w0 && be0[b]) after[a0][b*BW +: BW] = d0[b*BW +: BW];
    for (int d = 0; d < 2; d++) begin
      slot = (cyc + lat_of(d)) % 8;
      if (acc0) begin
        exp_v[d][0][slot] = 1'b1;
        exp_d[d][0][slot] = (w0 && rdw_new(d)) ? after[a0] : mem_m[a0];
      end
      if (acc1) begin
        exp_v[d][1][slot] = 1'b1;
        exp_d[d][1][slot] = (w1 && rdw_new(d)) ? after[a1] : mem_m[a1];
      end
    end
    coll_m = w0 && w1 && (a0 == a1) && |(be0 & be1);
    mem_m  = after;
  endtask

  function automatic logic [DW:0] get_out(int d, int p);
    logic [1:0] sel;
    sel = {d[0], p[0]};
    case (sel)
      2'b00:   return {bus_a.dout_valid0, bus_a.dout0};
      2'b01:   return {bus_a.dout_valid1, bus_a.dout1};
      2'b10:   return {bus_b.dout_valid0, bus_b.dout0};
      default: return {bus_b.dout_valid1, bus_b.dout1};
    endcase
  endfunction

  task automatic check_outputs();
    int slot;
    logic ev;
    logic [DW:0] o;
    slot = cyc % 8;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        ev = exp_v[d][p][slot];
        exp_v[d][p][slot] = 1'b0;
        if (ev) last_d[d][p] = exp_d[d][p][slot];
        o = get_out(d, p);
        chk($sformatf("valid d%0d p%0d cyc%0d", d, p, cyc), {31'd0, o[DW]}, {31'd0, ev});
        chk($sformatf("dout d%0d p%0d cyc%0d", d, p, cyc), o[DW-1:0], last_d[d][p]);
      end
    chk($sformatf("coll_a cyc%0d", cyc), {31'd0, bus_a.collision}, {31'd0, coll_m});
    chk($sformatf("coll_b cyc%0d", cyc), {31'd0, bus_b.collision}, {31'd0, coll_m});
    chk($sformatf("busy_a cyc%0d", cyc), {31'd0, bus_a.init_busy}, {31'd0, busy_left > 0});
    chk($sformatf("busy_b cyc%0d", cyc), {31'd0, bus_b.init_busy}, {31'd0, busy_left > 0});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    en0 = 0; en1 = 0; wr0 = 0; wr1 = 0; be0 = '0; be1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic op0(input logic w, input logic [LB-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    en0 = 1; wr0 = w; a0 = a; be0 = be; d0 = d;
  endtask

  task automatic op1(input logic w, input logic [LB-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    en1 = 1; wr1 = w; a1 = a; be1 = be; d1 = d;
  endtask

  int n;

  initial begin
    rst = 1'b1;
    idle();
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    busy_left = 0;
    coll_m = 1'b0;
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Clear window (or memory preload when the sequencer is compiled out),
    // then read every address on both ports.
`ifdef DPRAM_INIT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      op0(0, LB'(i), '0, '0); op1(0, LB'(i), '0, '0);
      tick();
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      op0(1, LB'(i), 4'hF, '0);
      tick();
    end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      op0(0, LB'(i), '0, '0); op1(0, LB'(DEPTH - 1 - i), '0, '0);
      tick();
      if (i > 0) chk("clear_read", bus_a.dout0, 32'h0);
    end
    idle(); tick(); tick();

    // Byte-enable merge
    op0(1, 4'd3, 4'hF, 32'hAABBCCDD); tick();
    op0(1, 4'd3, 4'h5, 32'h11223344); tick();
    op0(0, 4'd3, 4'h0, 32'h0);        tick();
    chk("be_merge_a", bus_a.dout0, 32'hAA22CC44);
    idle(); tick();
    chk("be_merge_b", bus_b.dout0, 32'hAA22CC44);
    tick();

    // Write-write collision on address 5
    op0(1, 4'd5, 4'h3, 32'h11111111); op1(1, 4'd5, 4'h6, 32'h22222222); tick();
    chk("collision_pulse", {31'd0, bus_a.collision}, 32'd1);
    idle(); op1(0, 4'd5, 4'h0, 32'h0); tick();
    chk("collision_pulse_end", {31'd0, bus_a.collision}, 32'd0);
    chk("collision_merge", bus_a.dout1, 32'h00221111);
    idle(); tick(); tick();

    // Read-during-write on address 7
    op0(1, 4'd7, 4'hF, 32'h5); tick();
    op0(1, 4'd7, 4'hF, 32'h9); op1(0, 4'd7, 4'h0, 32'h0); tick();
    chk("rdw_old_p0", bus_a.dout0, 32'h5);
    chk("rdw_cross_a", bus_a.dout1, 32'h5);
    idle(); tick();
    chk("rdw_new_p0", bus_b.dout0, 32'h9);
    chk("rdw_cross_b", bus_b.dout1, 32'h5);
    tick();

    // Continuous reads through the 2-cycle pipeline
    for (int i = 0; i < 4; i++) begin
      op0(0, LB'(i), '0, '0);
      tick();
      if (i >= 1) chk("lat2_valid", {31'd0, bus_b.dout_valid0}, 32'd1);
    end
    idle(); tick();
    chk("lat2_last", bus_b.dout0, 32'hAA22CC44);
    tick();

    // Randomised traffic, biased toward a few addresses to provoke overlaps
    for (int i = 0; i < 400; i++) begin
      en0 = ($urandom_range(0, 3) != 0); en1 = ($urandom_range(0, 3) != 0);
      wr0 = $urandom_range(0, 1);        wr1 = $urandom_range(0, 1);
      be0 = NB'($urandom);               be1 = NB'($urandom);
      a0  = ($urandom_range(0, 1) != 0) ? LB'($urandom_range(0, 3)) : LB'($urandom);
      a1  = ($urandom_range(0, 1) != 0) ? LB'($urandom_range(0, 3)) : LB'($urandom);
      d0  = $urandom;                    d1  = $urandom;
      tick();
    end
    idle(); tick(); tick();

    // Reset in the middle of a clear, with write attempts throughout
    do_reset();
    for (int i = 0; i < 8; i++) begin
      op0(1, LB'(i), 4'hF, $urandom); op1(1, LB'(i + 8), 4'hF, $urandom);
      tick();
    end
    do_reset();
    n = 0;
    while (bus_a.init_busy && n < 100) begin
      op0(1, 4'd9, 4'hF, $urandom);
      tick();
      n++;
    end
`ifdef DPRAM_INIT_CLEAR_EN
    chk("clear_len", n, DEPTH);
`else
    chk("clear_len", n, 0);
`endif
    op0(1, 4'd2, 4'hF, 32'hDEADBEEF); tick();
    idle(); tick();
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick();
    op0(0, 4'd2, '0, '0); tick();
`ifdef DPRAM_INIT_CLEAR_EN
    chk("addr2_after_clear", bus_a.dout0, 32'h0);
`else
    chk("addr2_after_clear", bus_a.dout0, 32'hDEADBEEF);
`endif
    idle(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
